// File: rtl/arith_pkg.sv
// arith_pkg: constants shared by the arithmetic lab datapath leaves.
//   RCA_DEFAULT_N : default operand/sum width of the ripple-carry adder.
package arith_pkg;
  localparam int RCA_DEFAULT_N = 16;
endpackage

// File: rtl/rca_full_adder.sv
// rca_full_adder: one-bit full adder cell, the repeated stage of the ripple chain.
// Ports:
//   a, b : operand bits
//   ci   : carry in from the next-lower stage
//   s    : sum bit
//   co   : carry out to the next-higher stage
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  // Propagate term is shared between the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/rca_behavioral_unsigned.sv
// rca_behavioral_unsigned: registered N-bit unsigned ripple-carry adder.
// Computes a + b + cin through a chain of N full adders and registers the
// result one cycle after an accepted input.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : operands valid this cycle
//   a, b      : N-bit unsigned operands
//   cin       : carry into bit 0
//   sum       : registered (a + b + cin) mod 2^N
//   cout      : registered carry out of bit N-1
//   v         : registered unsigned overflow flag (always equal to cout)
//   out_valid : sum/cout/v hold a new result this cycle
module rca_behavioral_unsigned
  import arith_pkg::*;
#(
  parameter int N = RCA_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         v,
  output logic         out_valid
);
  logic [N:0]   carry;
  logic [N-1:0] sum_next;

  logic [N-1:0] sum_reg;
  logic         cout_reg;
  logic         v_reg;
  logic         out_valid_reg;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      rca_full_adder u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (carry[gi]),
        .s  (sum_next[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Result registers load only on an accepted input, so undriven operands
  // during idle cycles never reach the outputs. For an unsigned add the
  // overflow flag is simply the final carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      v_reg         <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg  <= sum_next;
        cout_reg <= carry[N];
        v_reg    <= carry[N];
      end
    end
  end

  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign v         = v_reg;
  assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_rca_behavioral_unsigned.sv
module tb_rca_behavioral_unsigned;
  localparam int N = 16;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a, b;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout, v, out_valid;

  // Single-bit instance for the N = 1 width check.
  logic in_valid1, a1, b1, cin1;
  logic sum1, cout1, v1, out_valid1;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t held;

  always #5 clk = ~clk;

  rca_behavioral_unsigned #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .v(v), .out_valid(out_valid)
  );

  rca_behavioral_unsigned #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .v(v1), .out_valid(out_valid1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: whole-number addition of the accepted operands.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held.sum = '0; held.cout = 1'b0; held.v = 1'b0;
    end else if (in_valid) begin
      exp_t e;
      logic [N:0] full;
      full   = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      e.a    = a; e.b = b; e.cin = cin;
      e.sum  = full[N-1:0];
      e.cout = full[N];
      e.v    = full[N];
      exp_q.push_back(e);
    end
  end

  // Monitor: compares on the falling edge, away from the sampling edge.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 sum=0x%0h, expected no result", sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("txn 0x%04h + 0x%04h + %0d -> sum=0x%04h cout=%0d v=%0d (exp 0x%04h/%0d/%0d)",
                   e.a, e.b, e.cin, sum, cout, v, e.sum, e.cout, e.v);
          chk("sum", 32'(sum), 32'(e.sum));
          chk("cout", 32'(cout), 32'(e.cout));
          chk("v", 32'(v), 32'(e.v));
          held = e;
        end
      end else begin
        chk("missing_out_valid", 32'(out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk("hold", {15'd0, sum, cout, v}, {15'd0, held.sum, held.cout, held.v});
      end
    end
  end

  task automatic put(input logic vld, input logic [N-1:0] xa, input logic [N-1:0] xb,
                     input logic xc);
    @(negedge clk);
    in_valid = vld; a = xa; b = xb; cin = xc;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0001; cin = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout_v", {30'd0, cout, v}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    put(1'b0, '0, '0, 1'b0);
    put(1'b0, '0, '0, 1'b0);

    put(1'b1, 16'hFFAA, 16'h0000, 1'b0);
    put(1'b1, 16'hFFAA, 16'hFFAA, 1'b1);
    put(1'b0, '0, '0, 1'b0);
    put(1'b1, 16'd34, 16'd42, 1'b0);
    put(1'b1, 16'd7981, 16'd4342, 1'b0);
    put(1'b1, 16'd5456, 16'd4542, 1'b1);
    put(1'b1, 16'hFFFF, 16'hFFAA, 1'b1);
    put(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    put(1'b0, 16'h5555, 16'h1111, 1'b0);
    put(1'b0, 16'h0F0F, 16'hF0F0, 1'b1);
    put(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    put(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    put(1'b1, 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 200; i++) begin
      put(($urandom_range(0, 3) != 0), N'($urandom), N'($urandom), 1'($urandom));
    end

    // Reset mid-stream: the pending operation is dropped.
    put(1'b1, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h7777; b = 16'h8888; cin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    put(1'b0, '0, '0, 1'b0);
    put(1'b1, 16'h8000, 16'h8000, 1'b0);
    put(1'b0, '0, '0, 1'b0);

    // N = 1 width: all operand combinations.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      logic [1:0] full1;
      kv = 3'(k);
      @(negedge clk);
      in_valid1 = 1'b1; a1 = kv[2]; b1 = kv[1]; cin1 = kv[0];
      full1 = 2'(kv[2]) + 2'(kv[1]) + 2'(kv[0]);
      @(negedge clk);
      in_valid1 = 1'b0;
      $display("txn1 %0d + %0d + %0d -> sum=%0d cout=%0d v=%0d", kv[2], kv[1], kv[0], sum1, cout1, v1);
      chk("n1_out_valid", 32'(out_valid1), 32'd1);
      chk("n1_sum", 32'(sum1), 32'(full1[0]));
      chk("n1_cout_v", {30'd0, cout1, v1}, {30'd0, full1[1], full1[1]});
    end
    @(negedge clk);
    chk("n1_idle_out_valid", 32'(out_valid1), 32'd0);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rca_behavioral_unsigned.md
Name: rca_behavioral_unsigned

Overview:
- Registered N-bit unsigned ripple-carry adder: computes a + b + cin and produces sum, carry-out and unsigned overflow flag.
- Built as a chain of N one-bit full adders; result captured in an output register one cycle after an accepted input.
- Datapath leaf in the arithmetic lab hierarchy; no backpressure.

Parameters:
- N, 16, operand/sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid this cycle; sampled on rising edge.
- a  input  N  unsigned operand A.
- b  input  N  unsigned operand B.
- cin  input  1  carry-in into bit 0.
- sum  output  N  registered (a + b + cin) mod 2^N.
- cout  output  1  registered carry out of bit N-1.
- v  output  1  registered unsigned overflow flag.
- out_valid  output  1  sum/cout/v hold a new result this cycle.

Behaviour:
- One clock; reset synchronous, active-low. When rst_n = 0 at a rising edge: sum = 0, cout = 0, v = 0, out_valid = 0. Reset overrides a simultaneous in_valid, and the operation is discarded.
- Combinational core: c[0] = cin; for i = 0..N-1: s[i] = a[i] ^ b[i] ^ c[i], c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])). The full N+1-bit result {c[N], s} equals a + b + cin exactly.
- Unsigned overflow: v = c[N], so v always equals cout. The signed-overflow formula c[N] ^ c[N-1] is not used.
- Latency is 1 cycle. When in_valid = 1 at edge k, sum, cout and v update and out_valid = 1 after edge k.
- When in_valid = 0 at an edge, out_valid = 0 and sum, cout and v hold their previous values.
- Back-to-back in_valid gives one result per cycle, with full throughput and no stalls.
- Wrap-around: the sum is modulo 2^N. The maximum case a = b = 2^N-1 with cin = 1 gives sum = 2^N-1 and cout = v = 1.
- No X propagation from a, b or cin into registers when in_valid = 0, because the registers do not load.
- Reset mid-stream: a pending result is lost, and out_valid = 0 on the cycle after reset is released until the next accepted input.

Decomposition:
- Shared package (arith_pkg): default width constant RCA_DEFAULT_N = 16.
- Sub-module rca_full_adder (inputs a, b, ci; outputs s, co), instantiated N times in a generate loop. The output register lives in the top.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles while driving in_valid = 1, a = 0x1234 -> sum = 0, cout = 0, v = 0, out_valid = 0. After release with in_valid = 0, outputs stay 0.
- N=16, a = 0xFFAA, b = 0x0000, cin = 0 -> next cycle sum = 0xFFAA (65450), cout = 0, v = 0, out_valid = 1.
- a = 0xFFAA, b = 0xFFAA, cin = 1 -> sum = 0xFF55 (65365), cout = 1, v = 1.
- Back-to-back, one per cycle:
  - 34 + 42 + 0 -> 76, cout 0.
  - 7981 + 4342 + 0 -> 12323, cout 0.
  - 5456 + 4542 + 1 -> 9999, cout 0.
  - Results appear on three consecutive cycles with out_valid = 1.
- a = 0xFFFF, b = 0xFFAA, cin = 1 -> sum = 0xFFAA, cout = 1, v = 1. Then in_valid = 0 for 3 cycles -> outputs hold 0xFFAA/1/1 and out_valid = 0.
- Carry-chain and width checks:
  - a = 0xFFFF, b = 0x0000, cin = 1 -> sum = 0x0000, cout = 1.
  - N = 1: a = 1, b = 1, cin = 1 -> sum = 1, cout = 1.
  - Random sweep against the a + b + cin reference model.
